// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Optional macro CU_MEM_HANDSHAKE_EN stretches S_MEM/L_MEM until memReady is sampled high.
//
// state  | meaning
// FETCH  | load instruction register
// DECODE | select execute state from opcode
// R_EXE  | register-register ALU op, write rd, retire
// I_EXE  | register-immediate ALU op, write rd, retire
// LU_EXE | write imm to rd (LUI), retire
// AU_EXE | write PC+imm to rd (AUIPC), retire
// J_EXE  | write PC+4, PC <= PC+imm (JAL), retire
// JL_EXE | write PC+4, PC <= (rs1+imm)&~1 (JALR), retire
// B_EXE  | compare, PC <= PC+imm if taken, retire
// S_EXE  | compute store address
// S_MEM  | data write strobe, retire on completion
// L_EXE  | compute load address
// L_MEM  | data read strobe
// L_WB   | write load data to rd, retire
// TRAP   | illegal opcode, absorbing until reset
module multicycle_control_unit #(
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instrCode,
  input  logic                  btaken,
  input  logic                  memReady,
  output logic                  pcEn,
  output logic [1:0]            pcSrc,
  output logic                  irWe,
  output logic                  regFileWe,
  output logic [ALU_CTRL_W-1:0] aluControl,
  output logic                  aluSrcMuxSel,
  output logic                  dataWe,
  output logic                  dataRe,
  output logic [2:0]            rfWdSel,
  output logic                  instrRetired,
  output logic                  illegalInstr
);

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXE, I_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE,
    B_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;

  state_t      state, state_next;
  logic        run;
  logic        retire;
  logic        mem_done;
  logic        unused_bits;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        f7b;

  assign opcode = instrCode[6:0];
  assign f3     = instrCode[14:12];
  assign f7b    = instrCode[30];

`ifdef CU_MEM_HANDSHAKE_EN
  assign mem_done    = memReady;
  assign unused_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};
`else
  assign mem_done    = 1'b1;
  assign unused_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7], memReady};
`endif

  function automatic logic [ALU_CTRL_W-1:0] alu_code(input logic f7, input logic [2:0] fn3);
    logic [ALU_CTRL_W-1:0] r;
    r      = '0;
    r[3:0] = {f7, fn3};
    return r;
  endfunction

  // run holds FETCH for the first edge after reset so irWe is seen in that cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    retire       = 1'b0;
    pcEn         = 1'b0;
    pcSrc        = 2'd0;
    irWe         = 1'b0;
    regFileWe    = 1'b0;
    aluControl   = '0;
    aluSrcMuxSel = 1'b0;
    dataWe       = 1'b0;
    dataRe       = 1'b0;
    rfWdSel      = 3'd0;
    instrRetired = 1'b0;
    illegalInstr = 1'b0;

    case (state)
      FETCH: begin
        irWe       = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_R:    state_next = R_EXE;
          OP_I:    state_next = I_EXE;
          OP_L:    state_next = L_EXE;
          OP_S:    state_next = S_EXE;
          OP_B:    state_next = B_EXE;
          OP_LU:   state_next = LU_EXE;
          OP_AU:   state_next = AU_EXE;
          OP_J:    state_next = J_EXE;
          OP_JL:   state_next = JL_EXE;
          default: state_next = TRAP;
        endcase
      end
      R_EXE: begin
        aluControl = alu_code(f7b, f3);
        regFileWe  = 1'b1;
        retire     = 1'b1;
      end
      I_EXE: begin
        // only shift-right uses funct7[5] (SRAI); elsewhere it is immediate bits
        aluControl   = (f3 == 3'b101) ? alu_code(f7b, f3) : alu_code(1'b0, f3);
        aluSrcMuxSel = 1'b1;
        regFileWe    = 1'b1;
        retire       = 1'b1;
      end
      LU_EXE: begin
        regFileWe = 1'b1;
        rfWdSel   = 3'd2;
        retire    = 1'b1;
      end
      AU_EXE: begin
        regFileWe = 1'b1;
        rfWdSel   = 3'd3;
        retire    = 1'b1;
      end
      J_EXE: begin
        regFileWe = 1'b1;
        rfWdSel   = 3'd4;
        pcSrc     = 2'd1;
        retire    = 1'b1;
      end
      JL_EXE: begin
        regFileWe    = 1'b1;
        rfWdSel      = 3'd4;
        pcSrc        = 2'd2;
        aluSrcMuxSel = 1'b1;
        retire       = 1'b1;
      end
      B_EXE: begin
        aluControl = alu_code(1'b0, f3);
        pcSrc      = btaken ? 2'd1 : 2'd0;
        retire     = 1'b1;
      end
      S_EXE: begin
        aluSrcMuxSel = 1'b1;
        state_next   = S_MEM;
      end
      S_MEM: begin
        dataWe       = 1'b1;
        aluSrcMuxSel = 1'b1;
        retire       = mem_done;
      end
      L_EXE: begin
        aluSrcMuxSel = 1'b1;
        state_next   = L_MEM;
      end
      L_MEM: begin
        dataRe       = 1'b1;
        aluSrcMuxSel = 1'b1;
        if (mem_done) state_next = L_WB;
      end
      L_WB: begin
        regFileWe = 1'b1;
        rfWdSel   = 3'd1;
        retire    = 1'b1;
      end
      TRAP: begin
        illegalInstr = 1'b1;
        state_next   = TRAP;
      end
      default: state_next = FETCH;
    endcase

    if (retire) begin
      pcEn         = 1'b1;
      instrRetired = 1'b1;
      state_next   = FETCH;
    end

    // outputs drop combinationally with reset so no strobe outlives its assertion
    if (!(reset && run)) begin
      pcEn         = 1'b0;
      pcSrc        = 2'd0;
      irWe         = 1'b0;
      regFileWe    = 1'b0;
      aluControl   = '0;
      aluSrcMuxSel = 1'b0;
      dataWe       = 1'b0;
      dataRe       = 1'b0;
      rfWdSel      = 3'd0;
      instrRetired = 1'b0;
      illegalInstr = 1'b0;
    end
  end

endmodule
